pipe_stage_buf: RTL and testbench

Generic, parametrised pipeline stage register for the five-stage CPU. It replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single block.
- Payload is split into a control vector (write/memory enables) and a data vector (operands, immediates, register numbers, PC+4).
- Adds a valid/ready handshake, a 2-entry skid buffer (main + skid) so stalls do not create a combinational ready path, and a flush that turns contents into bubbles.
- Bubbles always present an all-zero control vector downstream.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_stage_slot.sv | 43 ++++
 rtl/pipe_stage_buf.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and per-stage constants for the pipeline stage buffers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Control-vector bit positions shared by all stages
  localparam int CTRL_WREG   = 0;
  localparam int CTRL_M2REG  = 1;
  localparam int CTRL_WMEM   = 2;
  localparam int CTRL_ALUIMM = 3;
  localparam int CTRL_SHIFT  = 4;
  localparam int CTRL_JAL    = 5;

  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 6;
  localparam int IDEX_DATA_W  = 137;
  localparam int EXMEM_CTRL_W = 3;
  localparam int EXMEM_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  // The state encoding doubles as the number of entries held.
  function automatic logic [1:0] occ_of(input stage_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One valid+ctrl+data holding register; clear turns it into a bubble (valid and ctrl zero).
module pipe_stage_slot #(
  parameter int CTRL_W        = 6,
  parameter int DATA_W        = 137,
  parameter bit DATA_RST_ZERO = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

  // Data only follows loads; bubbles leave it as-is.
  if (DATA_RST_ZERO) begin : g_data_rst
    always_ff @(posedge clock) begin
      if (reset)     data <= '0;
      else if (load) data <= in_data;
    end
  end else begin : g_data_norst
    always_ff @(posedge clock) begin
      if (load) data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, main+skid entries and flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W        = IDEX_CTRL_W,
  parameter int DATA_W        = IDEX_DATA_W,
  parameter bit DATA_RST_ZERO = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  // Handshake: a transfer happens on a posedge where valid and ready are both 1;
  // in_ready is registered so it never depends combinationally on out_ready.
  stage_state_e      state_q, state_d;
  logic              in_ready_q;
  logic              accept, emit;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;

  assign accept = in_valid & in_ready_q;
  assign emit   = main_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_BUSY;
        ST_BUSY: begin
          if (accept && !emit)      state_d = ST_FULL;
          else if (!accept && emit) state_d = ST_EMPTY;
        end
        ST_FULL:  if (emit) state_d = ST_BUSY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: main_load = accept;
        ST_BUSY: begin
          if (accept && emit) main_load  = 1'b1;
          else if (accept)    skid_load  = 1'b1;
          else if (emit)      main_clear = 1'b1;
        end
        ST_FULL: begin
          if (emit && skid_valid) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DATA_RST_ZERO(DATA_RST_ZERO)) u_main (
    .clock   (clock),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .in_ctrl (main_ctrl_in),
    .in_data (main_data_in),
    .valid   (main_valid),
    .ctrl    (main_ctrl),
    .data    (main_data)
  );

  pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DATA_RST_ZERO(DATA_RST_ZERO)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .in_ctrl (in_ctrl),
    .in_data (in_data),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = occ_of(state_q);

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && state_q != ST_EMPTY && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_buf;
  localparam int CTRL_W = 6;
  localparam int DATA_W = 137;
  localparam int W      = CTRL_W + DATA_W;

  logic              clock, reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cnt, flush_cnt;
  logic [31:0]       exp_stall, exp_flush;
`endif

  pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DATA_RST_ZERO(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: the stage is a FIFO of capacity two; head is what the stage presents.
  logic [W-1:0] exp_q[$];
  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic [W-1:0] head;
    logic         exp_valid;
    exp_valid = (exp_q.size() > 0);
    head = exp_valid ? exp_q[0] : '0;
    check("out_valid", 256'(out_valid), 256'(exp_valid));
    check("out_ctrl", 256'(out_ctrl), exp_valid ? 256'(head[W-1:DATA_W]) : 256'(0));
    if (exp_valid) check("out_data", 256'(out_data), 256'(head[DATA_W-1:0]));
    check("occupancy", 256'(occupancy), 256'(exp_q.size()));
    check("in_ready", 256'(in_ready), 256'(exp_q.size() < 2));
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 256'(stall_cnt), 256'(exp_stall));
    check("flush_cnt", 256'(flush_cnt), 256'(exp_flush));
`endif
  endtask

  // Drive one cycle's inputs, advance the model across the edge, then check.
  task automatic cycle(input logic rst, input logic iv, input logic fl, input logic orr,
                       input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    int  pre;
    bit  em, ac;
    reset = rst; in_valid = iv; flush = fl; out_ready = orr; in_ctrl = c; in_data = d;
    pre = exp_q.size();
    if (rst) begin
      exp_q.delete();
`ifdef PIPE_STAGE_PERF_EN
      exp_stall = 0; exp_flush = 0;
`endif
    end else begin
`ifdef PIPE_STAGE_PERF_EN
      if (pre > 0 && !orr && exp_stall != 32'hFFFF_FFFF) exp_stall++;
      if (fl && pre > 0 && exp_flush != 32'hFFFF_FFFF) exp_flush++;
`endif
      if (fl) exp_q.delete();
      else begin
        em = (pre > 0) && orr;
        ac = iv && (pre < 2);
        if (em) void'(exp_q.pop_front());
        if (ac) exp_q.push_back({c, d});
      end
    end
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] da, db;

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = 0; exp_flush = 0;
`endif
    @(negedge clock);

    // Reset held two cycles while upstream pushes
    cycle(1, 1, 0, 1, 6'h3F, rand_data());
    cycle(1, 1, 0, 1, 6'h3F, rand_data());
    check("rst_out_data", 256'(out_data), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(1));

    // Streaming 1..8 at full throughput
    for (int i = 1; i <= 8; i++) cycle(0, 1, 0, 1, CTRL_W'(i), DATA_W'(i));
    check("stream_last", 256'(out_data), 256'(8));
    cycle(0, 0, 0, 1, '0, '0);

    // Stall with A then B, then release
    da = rand_data(); db = rand_data();
    cycle(0, 1, 0, 0, 6'h01, da);
    cycle(0, 1, 0, 0, 6'h02, db);
    check("stall_occ", 256'(occupancy), 256'(2));
    check("stall_in_ready", 256'(in_ready), 256'(0));
    check("stall_head", 256'(out_data), 256'(da));
    cycle(0, 0, 0, 1, '0, '0);
    check("release_b", 256'(out_data), 256'(db));
    check("release_ready", 256'(in_ready), 256'(1));
    cycle(0, 0, 0, 1, '0, '0);

    // Flush while full, with a new input offered the same cycle
    cycle(0, 1, 0, 0, 6'h3F, rand_data());
    cycle(0, 1, 0, 0, 6'h3F, rand_data());
    cycle(0, 1, 1, 0, 6'h3F, rand_data());
    check("flush_occ", 256'(occupancy), 256'(0));
    check("flush_ctrl", 256'(out_ctrl), 256'(0));
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 6'h3F, rand_data());

    // Bubble mid-stream with live control bits on the bus
    cycle(0, 1, 0, 1, 6'h15, rand_data());
    cycle(0, 0, 0, 1, 6'h3F, rand_data());
    check("bubble_valid", 256'(out_valid), 256'(0));
    check("bubble_ctrl", 256'(out_ctrl), 256'(0));
    cycle(0, 1, 0, 1, 6'h2A, rand_data());
    cycle(0, 0, 0, 1, '0, '0);

`ifdef PIPE_STAGE_PERF_EN
    cycle(1, 0, 0, 0, '0, '0);
    cycle(0, 1, 0, 0, 6'h01, rand_data());
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, '0, '0);
    cycle(0, 0, 1, 1, '0, '0);
    check("perf_stall5", 256'(stall_cnt), 256'(5));
    check("perf_flush1", 256'(flush_cnt), 256'(1));
    cycle(1, 0, 0, 0, '0, '0);
    check("perf_rst_stall", 256'(stall_cnt), 256'(0));
    check("perf_rst_flush", 256'(flush_cnt), 256'(0));
`endif

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 6),
            CTRL_W'($urandom), rand_data());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
